// File: rtl/reg_file_sb.sv
// Integer register file for the ID stage: two combinational read ports with
// write bypass, optional hardwired zero register, pending-write scoreboard and post-reset clear.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              ready
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [NREGS];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  // Array has no reset; only the clear sequencer defines its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wd;
    wr_zero   = ZERO_REG && (waddr == '0);
    ready     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_RUN;
          clr_idx_d = '0;
        end
      end
      default: begin
        ready  = 1'b1;
        mem_we = we && !wr_zero;
        // Clear first so a same-index issue overrides it: the new producer wins.
        if (we) busy_d[waddr] = 1'b0;
        if (iss) busy_d[iss_addr] = 1'b1;
        if (ZERO_REG) busy_d[0] = 1'b0;
      end
    endcase
  end

  always_comb begin
    data1 = '0;
    data2 = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (state_q == ST_RUN) begin
      data1 = (we && waddr == addr1) ? wd : mem_q[addr1];
      data2 = (we && waddr == addr2) ? wd : mem_q[addr2];
      if (ZERO_REG && addr1 == '0) data1 = '0;
      if (ZERO_REG && addr2 == '0) data2 = '0;
      busy1 = busy_q[addr1];
      busy2 = busy_q[addr2];
      // A writeback retires the hazard combinationally unless re-issued this cycle.
      if (we && waddr == addr1 && !(iss && iss_addr == addr1)) busy1 = 1'b0;
      if (we && waddr == addr2 && !(iss && iss_addr == addr2)) busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against a behavioural model
// holding register values, pending flags and the clear countdown.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr1, addr2, waddr, iss_addr;
  logic [31:0] data1, data2, wd;
  logic        busy1, busy2, we, iss, ready;

  int n_chk  = 0;
  int n_fail = 0;

  bit          m_run;
  int          m_cnt;
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .waddr(waddr), .wd(wd),
    .iss(iss), .iss_addr(iss_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!m_run || a == 0) return 32'h0;
    if (we && waddr == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!m_run || a == 0) return 1'b0;
    if (iss && iss_addr == a) return m_busy[a];
    if (we && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic void model_step();
    if (!rst) begin
      model_reset();
    end else if (!m_run) begin
      m_mem[m_cnt] = 32'h0;
      m_cnt++;
      if (m_cnt == 32) m_run = 1'b1;
    end else begin
      if (we && waddr != 0) m_mem[waddr] = wd;
      if (we) m_busy[waddr] = 1'b0;
      if (iss && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endfunction

  task automatic check_outs();
    check("ready", {31'b0, ready}, {31'b0, m_run});
    check("data1", data1, exp_data(addr1));
    check("data2", data2, exp_data(addr2));
    check("busy1", {31'b0, busy1}, {31'b0, exp_busy(addr1)});
    check("busy2", {31'b0, busy2}, {31'b0, exp_busy(addr2)});
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic is, input logic [4:0] ia,
                       input logic [4:0] a1, input logic [4:0] a2);
    we = w; waddr = wa; wd = d; iss = is; iss_addr = ia; addr1 = a1; addr2 = a2;
    #2;
    check_outs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    we = 1'b0; waddr = '0; wd = '0; iss = 1'b0; iss_addr = '0; addr1 = '0; addr2 = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    model_reset();
    #3;
    check_outs();
    repeat (3) begin
      tick();
      drive(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 5'd5, 5'd3);
      check("rst_ready", {31'b0, ready}, 32'h0);
    end
    rst = 1'b1;

    // clear sequence with writes/issues that must be ignored
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'd5, 32'hDEAD, 1'($urandom), 5'($urandom), 5'd5, 5'($urandom));
      check("clr_ready", {31'b0, ready}, 32'h0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31);
    check("run_ready", {31'b0, ready}, 32'h1);
    check("reg5_zero", data1, 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 16));
      check("clr_lo", data1, 32'h0);
      check("clr_hi", data2, 32'h0);
      tick();
    end

    drive(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7);
    check("bypass7", data1, 32'h12345678);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    check("stored7", data1, 32'h12345678);
    tick();

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    check("zero_d", data1, 32'h0);
    check("zero_b", {31'b0, busy1}, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("zero_d2", data2, 32'h0);
    check("zero_b2", {31'b0, busy2}, 32'h0);
    tick();

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    check("iss3_same", {31'b0, busy1}, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    check("iss3_next", {31'b0, busy1}, 32'h1);
    tick();
    drive(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd3);
    check("wb3_busy", {31'b0, busy1}, 32'h0);
    check("wb3_data", data1, 32'hA5);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    check("wb3_after", {31'b0, busy1}, 32'h0);
    tick();

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    drive(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 5'd9, 5'd9);
    check("simul_b", {31'b0, busy1}, 32'h1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    check("simul_d", data1, 32'h11);
    check("simul_b2", {31'b0, busy1}, 32'h1);
    tick();

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      tick();
    end

    drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 5'd4, 5'd6);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd6);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd4, 5'd6);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    check("pre_b4", {31'b0, busy1}, 32'h1);
    check("pre_b6", {31'b0, busy2}, 32'h1);
    check("pre_d4", data1, 32'h55);
    #1;
    rst = 1'b0;
    #1;
    check("mid_ready", {31'b0, ready}, 32'h0);
    check("mid_b4", {31'b0, busy1}, 32'h0);
    check("mid_b6", {31'b0, busy2}, 32'h0);
    check("mid_d4", data1, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
      check("re_clr_ready", {31'b0, ready}, 32'h0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
    check("re_ready", {31'b0, ready}, 32'h1);
    check("re_d4", data1, 32'h0);
    check("re_b4", {31'b0, busy1}, 32'h0);
    check("re_b6", {31'b0, busy2}, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
